// File: rtl/trace_capture_ctrl_if.sv
// Bus bundle between trace_capture_ctrl, its trace sources, the trace_buffer and the JTAG readout.
// slave = controller view, master = environment view.
interface trace_capture_ctrl_if #(
    parameter int Fpay = 32,
    parameter int N    = 4
);
    logic [N-1:0]      src_valid;
    logic [N*Fpay-1:0] src_data;
    logic [N-1:0]      src_grant;
    logic [Fpay-1:0]   tb_trace;
    logic              tb_trigger;
    logic              tb_rd;
    logic [Fpay-1:0]   tb_dout;
    logic              rd_req;
    logic              rd_valid;
    logic [Fpay-1:0]   rd_data;

    modport master (
        output src_valid, src_data, tb_dout, rd_req,
        input  src_grant, tb_trace, tb_trigger, tb_rd, rd_valid, rd_data
    );

    modport slave (
        input  src_valid, src_data, tb_dout, rd_req,
        output src_grant, tb_trace, tb_trigger, tb_rd, rd_valid, rd_data
    );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Arm/trigger/post-trigger capture sequencer for one trace_buffer with round-robin source arbitration
// and JTAG readout. Optional drop counter port enabled by TRACE_CTRL_DROP_CNT_EN.
//
// state    | meaning
// IDLE     | waiting for arm
// CAPTURE  | storing arbitrated words, watching for trigger
// DONE     | capture finished, waiting for first read
// READOUT  | draining stored words to JTAG
module trace_capture_ctrl #(
    parameter int Fpay      = 32,
    parameter int N         = 4,
    parameter int DEPTH     = 512,
    parameter int POST_TRIG = 64,
    localparam int CW       = $clog2(DEPTH) + 1,
    localparam int IW       = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 trig_event,
    trace_capture_ctrl_if.slave  bus,
    output logic [1:0]           state,
    output logic [CW-1:0]        word_cnt,
    output logic                 full
`ifdef TRACE_CTRL_DROP_CNT_EN
    ,
    output logic [31:0]          drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  word_cnt_q, post_q;
    logic           full_q, rd_valid_q, trig_q;
    logic [IW-1:0]  rr_q;

    logic [IW-1:0]  gnt_idx;
    logic           gnt_any;
    logic           write, trig_now, rd_issue, done_trig, done_full;
    logic [CW-1:0]  word_nxt, post_nxt;

    // Round-robin search: lower offsets from rr_q overwrite higher ones, so offset 0 wins.
    always_comb begin
        logic [IW-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_q) + k) % N);
            if (bus.src_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign write     = (state_q == S_CAPTURE) && gnt_any;
    assign trig_now  = (state_q == S_CAPTURE) && trig_event && !trig_q;
    assign word_nxt  = word_cnt_q + CW'(write);
    assign post_nxt  = post_q + CW'(write && trig_q);
    // The trigger-cycle write is pre-trigger, so only writes after the latch count as post.
    assign done_trig = trig_q ? (post_nxt == CW'(POST_TRIG)) : (trig_now && (POST_TRIG == 0));
    assign done_full = (word_nxt == CW'(DEPTH));
    assign rd_issue  = ((state_q == S_DONE) || (state_q == S_READOUT)) && bus.rd_req
                       && (word_cnt_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (arm) state_d = S_CAPTURE;
            S_CAPTURE: if (done_trig || done_full) state_d = S_DONE;
            S_DONE: begin
                if (word_cnt_q == '0) state_d = S_IDLE;
                else if (rd_issue)    state_d = S_READOUT;
            end
            S_READOUT: begin
                if ((word_cnt_q == '0) || (rd_issue && (word_cnt_q == CW'(1))))
                    state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.src_grant  = '0;
        bus.tb_trace   = '0;
        bus.tb_trigger = write;
        bus.tb_rd      = rd_issue;
        for (int i = 0; i < N; i++) begin
            if (write && (gnt_idx == IW'(i))) begin
                bus.src_grant[i] = 1'b1;
                bus.tb_trace     = bus.src_data[i*Fpay +: Fpay];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q <= '0;
            post_q     <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            trig_q     <= 1'b0;
            rr_q       <= '0;
        end else begin
            rd_valid_q <= rd_issue;
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        word_cnt_q <= '0;
                        post_q     <= '0;
                        full_q     <= 1'b0;
                        trig_q     <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    word_cnt_q <= word_nxt;
                    post_q     <= post_nxt;
                    if (trig_now)  trig_q <= 1'b1;
                    if (done_full) full_q <= 1'b1;
                    if (write)     rr_q   <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
                end
                default: begin
                    if (rd_issue) word_cnt_q <= word_cnt_q - CW'(1);
                end
            endcase
        end
    end

`ifdef TRACE_CTRL_DROP_CNT_EN
    logic [31:0] drop_cnt_q, drop_add;
    logic [32:0] drop_sum;

    always_comb begin
        drop_add = '0;
        if (state_q == S_CAPTURE) begin
            for (int i = 0; i < N; i++)
                drop_add = drop_add + 32'(bus.src_valid[i] & ~bus.src_grant[i]);
        end
        drop_sum = {1'b0, drop_cnt_q} + {1'b0, drop_add};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           drop_cnt_q <= '0;
        else if (state_q == S_IDLE && arm)   drop_cnt_q <= '0;
        else if (drop_sum[32])               drop_cnt_q <= '1;
        else                                 drop_cnt_q <= drop_sum[31:0];
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign state        = state_q;
    assign word_cnt     = word_cnt_q;
    assign full         = full_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = bus.tb_dout;

endmodule
